// File: rtl/usb_rx_phy_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : usb_rx_phy_pkg
// Description : Shared line-state codes, SYNC/stuffing constants, receive FSM
//               states and token PIDs for the USB full-speed receive front end.
// Revision    : 1.0  initial release
// ============================================================================
package usb_rx_phy_pkg;

    // Line states as {dp, dn}
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    localparam logic [7:0] SYNC_PATTERN = 8'b01010100;
    localparam int         STUFF_LIMIT  = 6;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
        ST_EOP  = 3'd3,
        ST_ERR  = 3'd4
    } rx_state_e;

    function automatic logic is_data_line(input logic [1:0] ls);
        return (ls == LS_J) || (ls == LS_K);
    endfunction

endpackage

`default_nettype wire

// File: rtl/usb_rx_phy_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : usb_rx_phy_if
// Description : Pad inputs and decoded byte stream of the USB receive PHY.
// Revision    : 1.0  initial release
// ============================================================================
interface usb_rx_phy_if;
    logic       usb_dp;
    logic       usb_dn;
    logic       tx_active;
    logic       rx_active;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_eop;
    logic       rx_error;
    logic       usb_reset;

    modport master (
        input  usb_dp, usb_dn, tx_active,
        output rx_active, rx_data, rx_valid, rx_eop, rx_error, usb_reset
    );

    modport slave (
        output tx_active,
        input  rx_active, rx_data, rx_valid, rx_eop, rx_error, usb_reset
    );
endinterface

`default_nettype wire

// File: rtl/usb_rx_dpll.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : usb_rx_dpll
// Description : Pad synchronizers and 4x-oversampling bit-clock recovery.
// Revision    : 1.0  initial release
// ============================================================================
module usb_rx_dpll
    import usb_rx_phy_pkg::*;
(
    input  wire logic       clock48,
    input  wire logic       reset_n,
    input  wire logic       usb_dp,
    input  wire logic       usb_dn,
    output logic [1:0]      line_state,
    output logic            sample,
    output logic [1:0]      sample_line
);

    logic       dp_meta_q, dp_sync_q;
    logic       dn_meta_q, dn_sync_q;
    logic [1:0] line_prev_q;
    logic [1:0] phase_q, phase_d;

    assign line_state = {dp_sync_q, dn_sync_q};

    always_comb begin
        phase_d = phase_q + 2'd1;
        if (line_state != line_prev_q) begin
            phase_d = 2'd0;
        end
    end

    always_ff @(posedge clock48) begin
        if (!reset_n) begin
            dp_meta_q   <= 1'b1;
            dp_sync_q   <= 1'b1;
            dn_meta_q   <= 1'b0;
            dn_sync_q   <= 1'b0;
            line_prev_q <= LS_J;
            phase_q     <= 2'd0;
        end else begin
            dp_meta_q   <= usb_dp;
            dp_sync_q   <= dp_meta_q;
            dn_meta_q   <= usb_dn;
            dn_sync_q   <= dn_meta_q;
            line_prev_q <= line_state;
            phase_q     <= phase_d;
        end
    end

    // The bit is taken one cycle late so a short bit whose closing edge lands on
    // the strobe cycle is still sampled as itself rather than as its successor.
    assign sample      = (phase_q == 2'd2);
    assign sample_line = line_prev_q;

endmodule

`default_nettype wire

// File: rtl/usb_rx_phy.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : usb_rx_phy
// Description : USB full-speed receive front end: SYNC detect, NRZI decode,
//               bit unstuffing, byte assembly, EOP and bus-reset detection.
// Revision    : 1.0  initial release
// ============================================================================
module usb_rx_phy
    import usb_rx_phy_pkg::*;
#(
    parameter int RESET_CYCLES   = 120,
    parameter int SYNC_MIN_ZEROS = 3
) (
    input  wire logic     clock48,
    input  wire logic     reset_n,
    usb_rx_phy_if.master  bus
);

    localparam int              CNT_W   = $clog2(RESET_CYCLES + 1);
    localparam logic [CNT_W-1:0] RST_MAX = CNT_W'(RESET_CYCLES);
    localparam logic [3:0]      MIN_Z   = 4'(SYNC_MIN_ZEROS);
    localparam logic [2:0]      ONES_MX = 3'(STUFF_LIMIT);

    logic [1:0] line_state;
    logic       sample;
    logic [1:0] sample_line;

    usb_rx_dpll u_dpll (
        .clock48     (clock48),
        .reset_n     (reset_n),
        .usb_dp      (bus.usb_dp),
        .usb_dn      (bus.usb_dn),
        .line_state  (line_state),
        .sample      (sample),
        .sample_line (sample_line)
    );

    rx_state_e        state_q, state_d;
    logic [1:0]       prev_line_q, prev_line_d;
    logic [3:0]       zero_cnt_q, zero_cnt_d;
    logic [2:0]       ones_cnt_q, ones_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_eop_q, rx_eop_d;
    logic             rx_error_q, rx_error_d;
    logic [CNT_W-1:0] se0_cnt_q, se0_cnt_d;
    logic             nrzi_bit;

    assign nrzi_bit = (sample_line == prev_line_q);

    always_comb begin
        state_d     = state_q;
        prev_line_d = prev_line_q;
        zero_cnt_d  = zero_cnt_q;
        ones_cnt_d  = ones_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_eop_d    = 1'b0;
        rx_error_d  = 1'b0;

        if (bus.tx_active) begin
            state_d     = ST_IDLE;
            prev_line_d = LS_J;
        end else if (sample) begin
            case (state_q)
                ST_IDLE: begin
                    prev_line_d = sample_line;
                    if (prev_line_q == LS_J && sample_line == LS_K) begin
                        state_d    = ST_SYNC;
                        zero_cnt_d = 4'd1;
                    end
                end
                ST_SYNC: begin
                    prev_line_d = sample_line;
                    if (!is_data_line(sample_line)) begin
                        state_d = ST_IDLE;
                    end else if (!nrzi_bit) begin
                        if (zero_cnt_q != 4'hF) begin
                            zero_cnt_d = zero_cnt_q + 4'd1;
                        end
                    end else if (zero_cnt_q >= MIN_Z) begin
                        state_d    = ST_DATA;
                        ones_cnt_d = 3'd1;
                        bit_idx_d  = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (sample_line == LS_SE0) begin
                        state_d    = ST_EOP;
                        rx_eop_d   = 1'b1;
                        rx_error_d = (bit_idx_q != 3'd0);
                    end else if (sample_line == LS_SE1) begin
                        state_d    = ST_ERR;
                        rx_eop_d   = 1'b1;
                        rx_error_d = 1'b1;
                    end else begin
                        prev_line_d = sample_line;
                        if (ones_cnt_q == ONES_MX) begin
                            // Stuffed bit: must be a transition and is dropped
                            if (nrzi_bit) begin
                                state_d    = ST_ERR;
                                rx_eop_d   = 1'b1;
                                rx_error_d = 1'b1;
                            end else begin
                                ones_cnt_d = 3'd0;
                            end
                        end else begin
                            shift_d    = {nrzi_bit, shift_q[7:1]};
                            bit_idx_d  = bit_idx_q + 3'd1;
                            ones_cnt_d = nrzi_bit ? ones_cnt_q + 3'd1 : 3'd0;
                            if (bit_idx_q == 3'd7) begin
                                rx_data_d  = {nrzi_bit, shift_q[7:1]};
                                rx_valid_d = 1'b1;
                            end
                        end
                    end
                end
                ST_EOP, ST_ERR: begin
                    if (sample_line == LS_J) begin
                        state_d     = ST_IDLE;
                        prev_line_d = LS_J;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    prev_line_d = LS_J;
                end
            endcase
        end
    end

    always_comb begin
        se0_cnt_d = '0;
        if (line_state == LS_SE0) begin
            se0_cnt_d = (se0_cnt_q == RST_MAX) ? se0_cnt_q : se0_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock48) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            prev_line_q <= LS_J;
            zero_cnt_q  <= 4'd0;
            ones_cnt_q  <= 3'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            rx_eop_q    <= 1'b0;
            rx_error_q  <= 1'b0;
            se0_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_line_q <= prev_line_d;
            zero_cnt_q  <= zero_cnt_d;
            ones_cnt_q  <= ones_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_eop_q    <= rx_eop_d;
            rx_error_q  <= rx_error_d;
            se0_cnt_q   <= se0_cnt_d;
        end
    end

    assign bus.rx_active = (state_q == ST_DATA) && !bus.tx_active;
    assign bus.rx_valid  = rx_valid_q && !bus.tx_active;
    assign bus.rx_eop    = rx_eop_q   && !bus.tx_active;
    assign bus.rx_error  = rx_error_q && !bus.tx_active;
    assign bus.rx_data   = bus.tx_active ? 8'd0 : rx_data_q;
    assign bus.usb_reset = (se0_cnt_q == RST_MAX) && (line_state == LS_SE0);

endmodule

`default_nettype wire

// File: tb/tb_usb_rx_phy.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_usb_rx_phy
// Description : Self-checking bench for usb_rx_phy driving encoded packets.
// Revision    : 1.0  initial release
// ============================================================================
module tb_usb_rx_phy;
    import usb_rx_phy_pkg::*;

    localparam int  RESET_CYCLES = 120;
    localparam real BIT_NS       = 83.333;
    localparam real SLOW_NS      = 83.752;
    localparam real FAST_NS      = 82.919;

    logic clock48 = 1'b0;
    logic reset_n = 1'b0;

    usb_rx_phy_if bus();

    usb_rx_phy #(
        .RESET_CYCLES   (RESET_CYCLES),
        .SYNC_MIN_ZEROS (3)
    ) dut (
        .clock48 (clock48),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #10.4165 clock48 = ~clock48;

    int         tests_run    = 0;
    int         tests_failed = 0;

    logic [7:0] mon_bytes[$];
    int         mon_eop_cnt    = 0;
    int         mon_active_cnt = 0;
    int         mon_overlap    = 0;
    logic       mon_err        = 1'b0;

    logic [7:0] pkt[$];

    always @(negedge clock48) begin
        if (bus.rx_valid) mon_bytes.push_back(bus.rx_data);
        if (bus.rx_eop) begin
            mon_eop_cnt++;
            mon_err = bus.rx_error;
        end
        if (bus.rx_valid && bus.rx_eop) mon_overlap++;
        if (bus.rx_active) mon_active_cnt++;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder: SYNC, LSB-first payload bits, optional stuffing, NRZI, then EOP or SE1.
    task automatic send_packet(input int nbits, input real per, input bit stuff_en, input bit end_se1);
        logic [1:0] lvl;
        logic [1:0] wq[$];
        int         ones;
        logic       b;
        lvl  = LS_J;
        ones = 0;
        for (int i = 0; i < 8 + nbits; i++) begin
            if (i < 8) b = (i == 7);
            else       b = pkt[(i - 8) / 8][(i - 8) % 8];
            if (!b) lvl = (lvl == LS_J) ? LS_K : LS_J;
            wq.push_back(lvl);
            ones = b ? ones + 1 : 0;
            if (stuff_en && ones == 6) begin
                lvl = (lvl == LS_J) ? LS_K : LS_J;
                wq.push_back(lvl);
                ones = 0;
            end
        end
        if (end_se1) begin
            wq.push_back(LS_SE1);
        end else begin
            wq.push_back(LS_SE0);
            wq.push_back(LS_SE0);
        end
        for (int i = 0; i < 10; i++) wq.push_back(LS_J);
        foreach (wq[i]) begin
            {bus.usb_dp, bus.usb_dn} = wq[i];
            #(per);
        end
    endtask

    task automatic run_check(input string name, input int nbits, input real per, input bit stuff_en,
                             input bit end_se1, input int exp_n, input logic exp_err);
        int b0, e0;
        b0 = mon_bytes.size();
        e0 = mon_eop_cnt;
        send_packet(nbits, per, stuff_en, end_se1);
        @(negedge clock48);
        check_value({name, "_nbytes"}, mon_bytes.size() - b0, exp_n);
        for (int i = 0; i < exp_n && b0 + i < mon_bytes.size(); i++)
            check_value({name, "_byte"}, {24'd0, mon_bytes[b0 + i]}, {24'd0, pkt[i]});
        check_value({name, "_eop"}, mon_eop_cnt - e0, 1);
        check_value({name, "_err"}, {31'd0, mon_err}, {31'd0, exp_err});
        check_value({name, "_active"}, {31'd0, bus.rx_active}, 32'd0);
    endtask

    task automatic random_pkt(input int len);
        pkt.delete();
        for (int i = 0; i < len; i++) pkt.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        real rates[3];
        int  n, len, nbits, b0, e0, a0;
        real per;
        rates[0] = BIT_NS;
        rates[1] = SLOW_NS;
        rates[2] = FAST_NS;

        bus.usb_dp    = 1'b1;
        bus.usb_dn    = 1'b0;
        bus.tx_active = 1'b0;
        reset_n       = 1'b0;
        repeat (2) @(posedge clock48);
        @(negedge clock48);
        check_value("rst_active", {31'd0, bus.rx_active}, 32'd0);
        check_value("rst_valid",  {31'd0, bus.rx_valid},  32'd0);
        check_value("rst_eop",    {31'd0, bus.rx_eop},    32'd0);
        check_value("rst_error",  {31'd0, bus.rx_error},  32'd0);
        check_value("rst_usbrst", {31'd0, bus.usb_reset}, 32'd0);
        check_value("rst_data",   {24'd0, bus.rx_data},   32'd0);
        reset_n = 1'b1;

        repeat (48000) @(posedge clock48);
        @(negedge clock48);
        check_value("idle_valid", mon_bytes.size(), 0);
        check_value("idle_eop",   mon_eop_cnt, 0);

        pkt = '{8'h2D, 8'h00, 8'h10};
        run_check("setup", 24, BIT_NS, 1'b1, 1'b0, 3, 1'b0);

        pkt = '{8'hC3, 8'hFF, 8'hFF};
        run_check("stuff_nom",  24, BIT_NS,  1'b1, 1'b0, 3, 1'b0);
        run_check("stuff_slow", 24, SLOW_NS, 1'b1, 1'b0, 3, 1'b0);
        run_check("stuff_fast", 24, FAST_NS, 1'b1, 1'b0, 3, 1'b0);

        // Seven decoded ones after a zero with no stuffed bit: violation before any byte completes
        pkt = '{8'hFE};
        run_check("stuff_viol", 8, BIT_NS, 1'b0, 1'b0, 0, 1'b1);
        random_pkt(3);
        run_check("after_viol", 24, BIT_NS, 1'b1, 1'b0, 3, 1'b0);

        pkt = '{8'hA5, 8'h3C};
        run_check("se0_12bits", 12, BIT_NS, 1'b1, 1'b0, 1, 1'b1);
        pkt = '{8'h5A};
        run_check("se1_mid", 5, BIT_NS, 1'b1, 1'b1, 0, 1'b1);

        for (int k = 0; k < 8; k++) begin
            len   = int'($urandom_range(1, 4));
            random_pkt(len);
            per   = rates[$urandom_range(0, 2)];
            nbits = (k % 2 == 1) ? int'($urandom_range(1, 8 * len)) : 8 * len;
            run_check("rand", nbits, per, 1'b1, 1'b0, nbits / 8, (nbits % 8) != 0);
        end

        @(negedge clock48);
        {bus.usb_dp, bus.usb_dn} = LS_SE0;
        n = 0;
        while (!bus.usb_reset && n < 300) begin
            @(posedge clock48);
            #1;
            n++;
        end
        check_value("usbrst_latency", n, RESET_CYCLES + 2);
        repeat (144 - n) @(posedge clock48);
        #1;
        check_value("usbrst_hold", {31'd0, bus.usb_reset}, 32'd1);
        @(negedge clock48);
        {bus.usb_dp, bus.usb_dn} = LS_J;
        repeat (4) @(posedge clock48);
        #1;
        check_value("usbrst_release", {31'd0, bus.usb_reset}, 32'd0);
        #(BIT_NS * 4);

        b0 = mon_bytes.size();
        e0 = mon_eop_cnt;
        a0 = mon_active_cnt;
        @(negedge clock48);
        bus.tx_active = 1'b1;
        random_pkt(2);
        send_packet(16, BIT_NS, 1'b1, 1'b0);
        @(negedge clock48);
        check_value("tx_bytes",  mon_bytes.size() - b0, 0);
        check_value("tx_eop",    mon_eop_cnt - e0, 0);
        check_value("tx_active", mon_active_cnt - a0, 0);
        bus.tx_active = 1'b0;
        #(BIT_NS * 4);
        random_pkt(2);
        run_check("after_tx", 16, BIT_NS, 1'b1, 1'b0, 2, 1'b0);

        check_value("valid_eop_overlap", mon_overlap, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
